sm_accumulator: RTL and testbench



---
 rtl/sm_accumulator_if.sv | 26 ++
 rtl/sm_accumulator.sv | 148 ++++++++++++++
 tb/tb_sm_accumulator.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/sm_accumulator_if.sv
// Handshake bundle between the sign-magnitude adder and its accumulator.
// Input channel carries one sample; output channel carries a batch result.
interface sm_accumulator_if #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_mag;
    logic             in_sign;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_mag;
    logic             out_sign;
    logic             out_sat;

    modport master (
        output in_valid, in_mag, in_sign, out_ready,
        input  in_ready, out_valid, out_mag, out_sign, out_sat
    );

    modport slave (
        input  in_valid, in_mag, in_sign, out_ready,
        output in_ready, out_valid, out_mag, out_sign, out_sat
    );
endinterface

// File: rtl/sm_accumulator.sv
// Saturating batch accumulator of sign-magnitude samples.
// Optional SM_ACC_AVG_EN: output the batch average instead of the raw sum.
module sm_accumulator #(
    parameter int IN_W        = 5,
    parameter int ACC_W       = 8,
    parameter int NUM_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    sm_accumulator_if.slave bus
);
    localparam int CNT_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
`ifdef SM_ACC_AVG_EN
    localparam int SHIFT = $clog2(NUM_SAMPLES);
`else
    localparam int SHIFT = 0;
`endif
    localparam logic signed [ACC_W+1:0] MAXV =
        $signed({2'b00, {ACC_W{1'b1}}});
    localparam logic signed [ACC_W+1:0] MINV = -MAXV;

    generate
        if (NUM_SAMPLES < 1) begin : g_bad_num
            $error("sm_accumulator: NUM_SAMPLES must be >= 1");
        end
`ifdef SM_ACC_AVG_EN
        if ((NUM_SAMPLES & (NUM_SAMPLES - 1)) != 0) begin : g_bad_pow2
            $error("sm_accumulator: NUM_SAMPLES must be a power of 2");
        end
`endif
    endgenerate

    typedef enum logic {ACCUM, DONE} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [ACC_W:0]   r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_sat;
    logic [ACC_W-1:0]        r_mag;
    logic                    r_sign;
    logic                    r_osat;

    logic                    w_in_ready;
    logic                    w_out_valid;
    logic                    w_hs;
    logic                    w_last;
    logic signed [IN_W:0]    w_samp;
    logic signed [ACC_W+1:0] w_samp_x;
    logic signed [ACC_W+1:0] w_acc_x;
    logic signed [ACC_W+1:0] w_sum;
    logic                    w_hi;
    logic                    w_lo;
    logic signed [ACC_W:0]   w_sat_val;
    logic                    w_neg;
    logic [ACC_W-1:0]        w_abs;
    logic [ACC_W-1:0]        w_mag;

    // Negative zero collapses to +0 before it reaches the adder.
    assign w_samp   = (bus.in_sign && (bus.in_mag != '0))
                    ? -$signed({1'b0, bus.in_mag})
                    :  $signed({1'b0, bus.in_mag});
    assign w_samp_x = {{(ACC_W+1-IN_W){w_samp[IN_W]}}, w_samp};
    assign w_acc_x  = {r_acc[ACC_W], r_acc};
    assign w_sum    = w_acc_x + w_samp_x;
    assign w_hi     = (w_sum > MAXV);
    assign w_lo     = (w_sum < MINV);
    assign w_sat_val = w_hi ? MAXV[ACC_W:0]
                     : w_lo ? MINV[ACC_W:0]
                     : w_sum[ACC_W:0];

    // Clamped range keeps |acc| within ACC_W bits.
    assign w_neg = w_sat_val[ACC_W];
    assign w_abs = w_neg ? (~w_sat_val[ACC_W-1:0] + ACC_W'(1))
                         : w_sat_val[ACC_W-1:0];
    assign w_mag = w_abs >> SHIFT;

    assign w_last = (r_cnt == CNT_W'(NUM_SAMPLES - 1));
    assign w_hs   = bus.in_valid & w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        unique case (r_state)
            ACCUM: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
        if (clr) begin
            w_state_nxt = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_sat  <= 1'b0;
            r_mag  <= '0;
            r_sign <= 1'b0;
            r_osat <= 1'b0;
        end else if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_hs) begin
            r_acc <= w_sat_val;
            r_cnt <= r_cnt + CNT_W'(1);
            r_sat <= r_sat | w_hi | w_lo;
            if (w_last) begin
                r_mag  <= w_mag;
                r_sign <= w_neg && (w_mag != '0);
                r_osat <= r_sat | w_hi | w_lo;
            end
        end else if (w_out_valid && bus.out_ready) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_mag   = r_mag;
    assign bus.out_sign  = r_sign;
    assign bus.out_sat   = r_osat;
endmodule

// File: tb/tb_sm_accumulator.sv
// Directed bench for sm_accumulator: ACC_W=8 and ACC_W=6 instances.
// Expected values are hand-computed; AVG builds divide by NUM_SAMPLES.
module tb_sm_accumulator;
`ifdef SM_ACC_AVG_EN
    localparam int SH = 2;
`else
    localparam int SH = 0;
`endif

    logic clk;
    logic rst_n;
    logic clr8;
    logic clr6;
    int   checks;
    int   failures;

    sm_accumulator_if #(.IN_W(5), .ACC_W(8)) a ();
    sm_accumulator_if #(.IN_W(5), .ACC_W(6)) b ();

    sm_accumulator #(.IN_W(5), .ACC_W(8), .NUM_SAMPLES(4)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr8),
        .bus   (a)
    );

    sm_accumulator #(.IN_W(5), .ACC_W(6), .NUM_SAMPLES(4)) u6 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr6),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int em(input int m);
        return m >> SH;
    endfunction

    function automatic int es(input int neg, input int m);
        return (neg != 0 && (m >> SH) != 0) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push8(input int m, input int s);
        a.in_valid = 1'b1;
        a.in_mag   = 5'(m);
        a.in_sign  = s[0];
        @(negedge clk);
        a.in_valid = 1'b0;
    endtask

    task automatic push6(input int m, input int s);
        b.in_valid = 1'b1;
        b.in_mag   = 5'(m);
        b.in_sign  = s[0];
        @(negedge clk);
        b.in_valid = 1'b0;
    endtask

    task automatic accept8();
        a.out_ready = 1'b1;
        @(negedge clk);
        a.out_ready = 1'b0;
    endtask

    task automatic accept6();
        b.out_ready = 1'b1;
        @(negedge clk);
        b.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        clr8        = 1'b0;
        clr6        = 1'b0;
        a.in_valid  = 1'b0;
        a.in_mag    = '0;
        a.in_sign   = 1'b0;
        a.out_ready = 1'b0;
        b.in_valid  = 1'b0;
        b.in_mag    = '0;
        b.in_sign   = 1'b0;
        b.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", a.in_ready, 1);
        chk("rst_out_valid", a.out_valid, 0);
        chk("rst_out_mag", a.out_mag, 0);
        chk("rst_out_sign", a.out_sign, 0);
        chk("rst_out_sat", a.out_sat, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: async reset mid-batch
        push8(1, 0);
        push8(1, 0);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_in_ready", a.in_ready, 1);
        chk("t1_rst_out_valid", a.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push8(1, 0);
        push8(1, 0);
        push8(1, 0);
        chk("t1_no_early_valid", a.out_valid, 0);
        push8(1, 0);
        chk("t1_out_valid", a.out_valid, 1);
        chk("t1_out_mag", a.out_mag, em(4));
        chk("t1_out_sign", a.out_sign, 0);
        chk("t1_out_sat", a.out_sat, 0);
        accept8();
        chk("t1_acc_out_valid", a.out_valid, 0);
        chk("t1_acc_in_ready", a.in_ready, 1);

        // Test 2: mixed signs with gaps, sum -8
        push8(5, 0);
        @(negedge clk);
        push8(3, 1);
        @(negedge clk);
        push8(10, 0);
        @(negedge clk);
        chk("t2_no_early_valid", a.out_valid, 0);
        push8(20, 1);
        chk("t2_out_valid", a.out_valid, 1);
        chk("t2_out_mag", a.out_mag, em(8));
        chk("t2_out_sign", a.out_sign, es(1, 8));
        chk("t2_out_sat", a.out_sat, 0);

        // Test 4: backpressure with in_valid held high
        a.in_valid = 1'b1;
        a.in_mag   = 5'd7;
        a.in_sign  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_out_valid", a.out_valid, 1);
            chk("t4_out_mag", a.out_mag, em(8));
            chk("t4_out_sign", a.out_sign, es(1, 8));
            chk("t4_in_ready", a.in_ready, 0);
        end
        a.in_valid = 1'b0;
        accept8();
        chk("t4_in_ready_after", a.in_ready, 1);
        chk("t4_out_valid_after", a.out_valid, 0);
        chk("t4_mag_hold", a.out_mag, em(8));

        // Test 5: negative zero, also proves acc cleared
        push8(0, 1);
        push8(7, 0);
        push8(7, 1);
        push8(0, 1);
        chk("t5_out_valid", a.out_valid, 1);
        chk("t5_out_mag", a.out_mag, 0);
        chk("t5_out_sign", a.out_sign, 0);
        chk("t5_out_sat", a.out_sat, 0);
        accept8();

        // Test 6: clr drops batch and the sample in its cycle
        push8(9, 0);
        push8(9, 0);
        clr8       = 1'b1;
        a.in_valid = 1'b1;
        a.in_mag   = 5'd9;
        a.in_sign  = 1'b0;
        @(negedge clk);
        clr8       = 1'b0;
        a.in_valid = 1'b0;
        push8(2, 0);
        push8(2, 0);
        push8(2, 0);
        chk("t6_no_early_valid", a.out_valid, 0);
        push8(2, 0);
        chk("t6_out_valid", a.out_valid, 1);
        chk("t6_out_mag", a.out_mag, em(8));
        chk("t6_out_sign", a.out_sign, 0);

        // clr while a result is pending
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        chk("t6_clr_done_valid", a.out_valid, 0);
        chk("t6_clr_done_ready", a.in_ready, 1);
        push8(1, 0);
        push8(1, 0);
        push8(1, 0);
        push8(1, 0);
        chk("t6_post_clr_mag", a.out_mag, em(4));
        accept8();

        // Test 3: ACC_W=6 saturation, then sticky flag cleared
        push6(31, 0);
        push6(31, 0);
        push6(31, 0);
        push6(31, 0);
        chk("t3_out_valid", b.out_valid, 1);
        chk("t3_sat_mag", b.out_mag, em(63));
        chk("t3_sat_sign", b.out_sign, 0);
        chk("t3_sat_flag", b.out_sat, 1);
        accept6();
        push6(1, 1);
        push6(1, 1);
        push6(1, 1);
        push6(1, 1);
        chk("t3_neg_mag", b.out_mag, em(4));
        chk("t3_neg_sign", b.out_sign, es(1, 4));
        chk("t3_neg_sat", b.out_sat, 0);
        accept6();

        // negative saturation on ACC_W=6
        push6(31, 1);
        push6(31, 1);
        push6(31, 1);
        push6(31, 1);
        chk("t3_nsat_mag", b.out_mag, em(63));
        chk("t3_nsat_sign", b.out_sign, es(1, 63));
        chk("t3_nsat_flag", b.out_sat, 1);
        accept6();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
